// File: rtl/spike_packet_sink.sv
// spike_packet_sink: buffers routed spike packets and folds them into one spike vector per time step
// Ports: neu_clk/rst_n (sync, active low); packet_valid/packet_in/packet_ready accept router packets;
// start marks a step boundary; spike_vector/spike_valid/step_index report each finished step;
// drop_count counts packets addressed elsewhere; step_overrun flags a start lost during a pending flush.
module spike_packet_sink #(
    parameter int         PACKET_SIZE     = 32,
    parameter int         AXON_ADDR_WIDTH = 5,
    parameter int         FIFO_ADDR_WIDTH = 3,
    parameter logic [3:0] LOCAL_X         = 4'd0,
    parameter logic [3:0] LOCAL_Y         = 4'd0
) (
    input  logic                            neu_clk,
    input  logic                            rst_n,
    input  logic                            packet_valid,
    input  logic [PACKET_SIZE-1:0]          packet_in,
    output logic                            packet_ready,
    input  logic                            start,
    output logic [(1<<AXON_ADDR_WIDTH)-1:0] spike_vector,
    output logic                            spike_valid,
    output logic [7:0]                      step_index,
    output logic [7:0]                      drop_count,
    output logic                            step_overrun
);
    localparam int EW = 8 + AXON_ADDR_WIDTH;
    localparam int CW = FIFO_ADDR_WIDTH + 1;
    localparam int N  = 1 << FIFO_ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_APPLY = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    logic [EW-1:0]                  mem [N];
    logic [EW-1:0]                  rd_data;
    logic [FIFO_ADDR_WIDTH-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]                  count;
    logic [2:0]                     state, state_n;
    logic [(1<<AXON_ADDR_WIDTH)-1:0] acc;
    logic                           active, pending, push, pop, match, go;
    logic                           unused_reserved;

    assign unused_reserved = ^packet_in[PACKET_SIZE-9:AXON_ADDR_WIDTH];
    assign packet_ready = active && (count != DEPTH);
    assign push  = packet_valid && packet_ready;
    assign pop   = state == S_READ;
    assign match = rd_data[EW-1 -: 4] == LOCAL_X && rd_data[EW-5 -: 4] == LOCAL_Y;
    assign go    = start || pending;

    always_comb begin
        state_n = (state == S_IDLE)  ? (go ? S_FLUSH : (count != '0 ? S_READ : S_IDLE)) :
                  (state == S_READ)  ? S_APPLY :
                  (state == S_APPLY) ? (go ? S_FLUSH : S_IDLE) :
                  (state == S_FLUSH) ? (count != '0 ? S_READ : S_EMIT) : S_IDLE;
    end

    always_ff @(posedge neu_clk) begin
        if (push)
            mem[wr_ptr] <= {packet_in[PACKET_SIZE-1 -: 8], packet_in[AXON_ADDR_WIDTH-1:0]};
    end

    always_ff @(posedge neu_clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data      <= '0;
            acc          <= '0;
            pending      <= 1'b0;
            active       <= 1'b0;
            spike_vector <= '0;
            spike_valid  <= 1'b0;
            step_index   <= '0;
            drop_count   <= '0;
            step_overrun <= 1'b0;
        end else begin
            active      <= 1'b1;
            state       <= state_n;
            count       <= count + CW'(push) - CW'(pop);
            spike_valid <= state == S_EMIT;
            if (push)
                wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            end
            if (state == S_APPLY && match)
                acc[rd_data[AXON_ADDR_WIDTH-1:0]] <= 1'b1;
            if (state == S_APPLY && !match && drop_count != 8'hff)
                drop_count <= drop_count + 8'd1;
            // a start is only honoured once per step; extras while one is queued are flagged
            if (start && (pending || state == S_FLUSH || state == S_EMIT))
                step_overrun <= 1'b1;
            else if (start)
                pending <= 1'b1;
            if (state == S_EMIT) begin
                spike_vector <= acc;
                acc          <= '0;
                step_index   <= step_index + 8'd1;
                pending      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spike_packet_sink.sv
// tb_spike_packet_sink: randomized and directed bench comparing spike_packet_sink against a queue-based model
module tb_spike_packet_sink;
    localparam int IDLE = 0, READ = 1, APPLY = 2, FLUSH = 3, EMIT = 4;
    localparam logic [3:0] LX = 4'd0, LY = 4'd0;

    logic        neu_clk = 0, rst_n = 0, packet_valid = 0, start = 0;
    logic [31:0] packet_in = 0;
    logic        packet_ready, spike_valid, step_overrun;
    logic [31:0] spike_vector;
    logic [7:0]  step_index, drop_count;
    int          checks = 0, errors = 0;
    bit          chk_on = 0;

    always #5 neu_clk = ~neu_clk;

    spike_packet_sink dut (
        .neu_clk(neu_clk), .rst_n(rst_n), .packet_valid(packet_valid), .packet_in(packet_in),
        .packet_ready(packet_ready), .start(start), .spike_vector(spike_vector),
        .spike_valid(spike_valid), .step_index(step_index), .drop_count(drop_count),
        .step_overrun(step_overrun)
    );

    int          m_mode;
    logic [31:0] m_q[$];
    logic [31:0] m_head, m_acc, m_vec;
    bit          m_pend, m_valid, m_ovr, m_live;
    logic [7:0]  m_idx, m_drop;

    always @(posedge neu_clk) begin
        if (!rst_n) begin
            m_mode = IDLE; m_q.delete(); m_head = 0; m_acc = 0; m_vec = 0;
            m_pend = 0; m_valid = 0; m_ovr = 0; m_live = 0; m_idx = 0; m_drop = 0;
        end else begin
            bit push, go;
            int nm;
            push = packet_valid && m_live && m_q.size() < 8;
            go = start || m_pend;
            m_valid = m_mode == EMIT;
            nm = IDLE;
            case (m_mode)
                IDLE:  nm = go ? FLUSH : (m_q.size() != 0 ? READ : IDLE);
                READ:  begin m_head = m_q.pop_front(); nm = APPLY; end
                APPLY: begin
                    if (m_head[31:28] == LX && m_head[27:24] == LY) m_acc[m_head[4:0]] = 1'b1;
                    else if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
                    nm = go ? FLUSH : IDLE;
                end
                FLUSH: nm = m_q.size() != 0 ? READ : EMIT;
                default: begin m_vec = m_acc; m_acc = 0; m_idx = m_idx + 8'd1; end
            endcase
            if (start && (m_pend || m_mode == FLUSH || m_mode == EMIT)) m_ovr = 1;
            else if (start) m_pend = 1;
            if (m_mode == EMIT) m_pend = 0;
            if (push) m_q.push_back(packet_in);
            m_mode = nm;
            m_live = 1;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge neu_clk) begin
        if (chk_on) begin
            chk("ready", packet_ready, m_live && m_q.size() < 8);
            chk("spike_valid", spike_valid, m_valid);
            chk("spike_vector", spike_vector, m_vec);
            chk("step_index", step_index, m_idx);
            chk("drop_count", drop_count, m_drop);
            chk("step_overrun", step_overrun, m_ovr);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge neu_clk); #2; end
    endtask

    task automatic rst();
        rst_n = 0; packet_valid = 0; start = 0;
        cyc();
        chk("rst_ready", packet_ready, 0);
        chk("rst_valid", spike_valid, 0);
        chk("rst_vector", spike_vector, 0);
        chk("rst_index", step_index, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_overrun", step_overrun, 0);
        rst_n = 1;
        cyc();
        chk("ready_after_release", packet_ready, 1);
    endtask

    task automatic send(input logic [3:0] x, input logic [3:0] y, input logic [4:0] a);
        bit ok;
        int b;
        packet_valid = 1; packet_in = {x, y, 19'd0, a}; b = 0;
        do begin ok = packet_ready; cyc(); b++; end while (!ok && b < 100);
        if (!ok) chk("send_timeout", 0, 1);
        packet_valid = 0;
    endtask

    task automatic step_pulses(output int p);
        start = 1; cyc(); start = 0; p = 0;
        repeat (12) begin if (spike_valid) p++; cyc(); end
    endtask

    initial begin
        int p, n, b;
        bit ok, low_seen;
        rst_n = 0;
        cyc();
        chk_on = 1;
        rst();
        send(LX, LY, 3); send(LX, LY, 7); send(LX, LY, 3);
        cyc(10);
        start = 1; cyc(); start = 0;
        chk("t1_lat_k", spike_valid, 0);
        cyc();
        chk("t1_lat_k1", spike_valid, 0);
        cyc();
        chk("t1_lat_k2", spike_valid, 1);
        chk("t1_vector", spike_vector, 32'h0000_0088);
        chk("t1_index", step_index, 1);
        cyc();
        chk("t1_one_pulse", spike_valid, 0);

        rst();
        n = 0; b = 0; low_seen = 0; packet_valid = 1;
        while (n < 20 && b < 300) begin
            packet_in = {LX, LY, 19'd0, 5'(n)};
            ok = packet_ready;
            if (!ok) low_seen = 1;
            cyc(); b++;
            if (ok) n++;
        end
        packet_valid = 0;
        chk("t2_accepts", n, 20);
        chk("t2_ready_dropped", low_seen, 1);
        cyc(80);
        step_pulses(p);
        chk("t2_vector", spike_vector, 32'h000F_FFFF);
        chk("t2_pulses", p, 1);

        rst();
        send(4'd1, LY, 5);
        cyc(6);
        chk("t3_drop", drop_count, 1);
        step_pulses(p);
        chk("t3_vector", spike_vector, 0);

        rst();
        cyc(2);
        send(LX, LY, 9);
        cyc(2);
        start = 1; cyc(2); start = 0;
        p = 0;
        repeat (10) begin if (spike_valid) p++; cyc(); end
        chk("t4_pulses", p, 1);
        chk("t4_overrun", step_overrun, 1);
        chk("t4_vector", spike_vector, 32'h0000_0200);
        chk("t4_index", step_index, 1);

        rst();
        for (int i = 0; i < 256; i++) begin
            start = 1; cyc(); start = 0; cyc(4);
            if (i == 254) chk("t5_index_255", step_index, 255);
        end
        chk("t5_index_wrap", step_index, 0);
        for (int i = 0; i < 300; i++) send(4'd1, 4'd1, 5'(i));
        cyc(40);
        chk("t5_drop_sat", drop_count, 255);

        rst();
        packet_valid = 1;
        for (int i = 0; i < 7; i++) begin packet_in = {LX, LY, 19'd0, 5'(i + 1)}; cyc(); end
        packet_valid = 0;
        rst_n = 0; cyc();
        chk("t6_ready_in_reset", packet_ready, 0);
        rst_n = 1; cyc();
        chk("t6_ready_release", packet_ready, 1);
        p = 0;
        repeat (5) begin if (spike_valid) p++; cyc(); end
        chk("t6_no_pulse", p, 0);
        step_pulses(p);
        chk("t6_vector", spike_vector, 0);
        chk("t6_pulses", p, 1);

        rst();
        for (int i = 0; i < 3000; i++) begin
            packet_valid = 1'($urandom_range(0, 1));
            packet_in = $urandom;
            packet_in[31:28] = ($urandom_range(0, 3) == 0) ? 4'd1 : LX;
            packet_in[27:24] = ($urandom_range(0, 3) == 0) ? 4'd2 : LY;
            start = $urandom_range(0, 29) == 0;
            rst_n = $urandom_range(0, 999) != 0;
            cyc();
        end
        rst_n = 1; packet_valid = 0; start = 0;
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
